// File: rtl/spw_tx_char_scheduler.sv
// ---------------------------------------------------------------------------
// spw_tx_char_scheduler
//
// Transmit-side character scheduler for a SpaceWire codec. Each time the
// encoder is free it picks the next character to send (time-code, FCT,
// N-char from the TX FIFO, or NULL), offers it with a valid/ready handshake,
// and keeps the transmit credit earned from FCTs the receiver has seen.
//
// Ports
//   CLOCK, RESET          system clock, asynchronous active-high reset
//   enableTx              transmitter enable from the link FSM
//   sendNULLs/FCTs/NChars/TimeCodes
//                         per-character-type permissions from the link FSM
//   tickIn, timeIn[7:0]   time-code request pulse and its value
//   sendFctReq/Ack        FCT request (level) from RX credit logic / accept
//   txFifoData[8:0]       show-ahead FIFO word (bit 8 set = EOP/EEP marker)
//   txFifoEmpty/Read      FIFO empty flag / pop strobe
//   gotFCT                received-FCT pulse (already in CLOCK domain)
//   charType[2:0]         0 NULL, 1 FCT, 2 DATA, 3 EOP, 4 EEP, 5 TIMECODE
//   charData[7:0]         data byte or time value, 0 otherwise
//   charValid/charReady   handshake with the character encoder
//   txCredit              current transmit credit
//   creditErr             one-cycle pulse on credit overflow
// ---------------------------------------------------------------------------
module spw_tx_char_scheduler #(
    parameter int MAX_CREDIT  = 56,
    parameter int CREDIT_STEP = 8,
    parameter int CREDIT_W    = 6
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                enableTx,
    input  logic                sendNULLs,
    input  logic                sendFCTs,
    input  logic                sendNChars,
    input  logic                sendTimeCodes,
    input  logic                tickIn,
    input  logic [7:0]          timeIn,
    input  logic                sendFctReq,
    output logic                sendFctAck,
    input  logic [8:0]          txFifoData,
    input  logic                txFifoEmpty,
    output logic                txFifoRead,
    input  logic                gotFCT,
    output logic [2:0]          charType,
    output logic [7:0]          charData,
    output logic                charValid,
    input  logic                charReady,
    output logic [CREDIT_W-1:0] txCredit,
    output logic                creditErr
);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_SELECT,
        ST_HOLD
    } state_t;

    typedef enum logic [2:0] {
        CH_NULL = 3'd0,
        CH_FCT  = 3'd1,
        CH_DATA = 3'd2,
        CH_EOP  = 3'd3,
        CH_EEP  = 3'd4,
        CH_TIME = 3'd5
    } char_t;

    // One extra bit so credit + CREDIT_STEP can be compared without wrapping.
    localparam int SUM_W = CREDIT_W + 1;

    state_t              state_q, state_d;
    char_t               char_type_q, char_type_d;
    logic [7:0]          char_data_q, char_data_d;
    logic                char_valid_q, char_valid_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                credit_err_q, credit_err_d;
    logic                tick_pend_q, tick_pend_d;
    logic [7:0]          tick_val_q, tick_val_d;

    logic                accept;
    logic                nchar_accept;
    logic                time_accept;
    logic [SUM_W-1:0]    credit_base;
    logic [SUM_W-1:0]    credit_sum;

    // A disabled transmitter must not consume anything, so enableTx gates
    // the handshake even when the encoder raises charReady.
    assign accept       = enableTx && char_valid_q && charReady;
    assign nchar_accept = accept && (char_type_q == CH_DATA ||
                                     char_type_q == CH_EOP  ||
                                     char_type_q == CH_EEP);
    assign time_accept  = accept && (char_type_q == CH_TIME);

    assign sendFctAck = accept && (char_type_q == CH_FCT);
    assign txFifoRead = nchar_accept;

    assign charType  = char_type_q;
    assign charData  = char_data_q;
    assign charValid = char_valid_q;
    assign txCredit  = credit_q;
    assign creditErr = credit_err_q;

    // Character selection and handshake hold.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        char_type_d  = char_type_q;
        char_data_d  = char_data_q;
        char_valid_d = char_valid_q;

        case (state_q)
            ST_DISABLED: begin
                state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (tick_pend_q && sendTimeCodes) begin
                    char_type_d  = CH_TIME;
                    char_data_d  = tick_val_q;
                    char_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else if (sendFCTs && sendFctReq) begin
                    char_type_d  = CH_FCT;
                    char_data_d  = 8'h00;
                    char_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else if (sendNChars && !txFifoEmpty && credit_q != '0) begin
                    // Bit 8 marks an end-of-packet; a zero payload is EOP,
                    // anything else is an error end-of-packet.
                    if (!txFifoData[8]) begin
                        char_type_d = CH_DATA;
                        char_data_d = txFifoData[7:0];
                    end else if (txFifoData[7:0] == 8'h00) begin
                        char_type_d = CH_EOP;
                        char_data_d = 8'h00;
                    end else begin
                        char_type_d = CH_EEP;
                        char_data_d = 8'h00;
                    end
                    char_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else if (sendNULLs) begin
                    char_type_d  = CH_NULL;
                    char_data_d  = 8'h00;
                    char_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d      = ST_SELECT;
                    char_type_d  = CH_NULL;
                    char_data_d  = 8'h00;
                    char_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_DISABLED;
            end
        endcase

        if (!enableTx) begin
            state_d      = ST_DISABLED;
            char_type_d  = CH_NULL;
            char_data_d  = 8'h00;
            char_valid_d = 1'b0;
        end
    end

    // Pending time-code: a new tick overrides both an older value and the
    // clear caused by sending the previous time-code in the same cycle.
    always_comb begin
        tick_pend_d = tick_pend_q;
        tick_val_d  = tick_val_q;
        if (time_accept) begin
            tick_pend_d = 1'b0;
        end
        if (tickIn && sendTimeCodes) begin
            tick_pend_d = 1'b1;
            tick_val_d  = timeIn;
        end
        if (!enableTx) begin
            tick_pend_d = 1'b0;
            tick_val_d  = 8'h00;
        end
    end

    // Credit: consume one per N-char, add CREDIT_STEP per received FCT. An
    // FCT that would push past MAX_CREDIT is dropped and flagged instead.
    always_comb begin
        credit_base  = {1'b0, credit_q} - SUM_W'(nchar_accept);
        credit_sum   = credit_base + SUM_W'(CREDIT_STEP);
        credit_d     = credit_base[CREDIT_W-1:0];
        credit_err_d = 1'b0;
        if (gotFCT) begin
            if (credit_sum > SUM_W'(MAX_CREDIT)) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_sum[CREDIT_W-1:0];
            end
        end
        if (!enableTx) begin
            credit_d     = '0;
            credit_err_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_DISABLED;
            char_type_q  <= CH_NULL;
            char_data_q  <= 8'h00;
            char_valid_q <= 1'b0;
            credit_q     <= '0;
            credit_err_q <= 1'b0;
            tick_pend_q  <= 1'b0;
            tick_val_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            char_type_q  <= char_type_d;
            char_data_q  <= char_data_d;
            char_valid_q <= char_valid_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            tick_pend_q  <= tick_pend_d;
            tick_val_q   <= tick_val_d;
        end
    end

endmodule

// File: tb/tb_spw_tx_char_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spw_tx_char_scheduler
//
// Directed bench for spw_tx_char_scheduler. A transaction-level model of the
// scheduler runs alongside the DUT and every negative clock edge compares
// all outputs against it; directed sequences add hand-computed literal
// expectations (accepted character stream, credit values, pulse counts).
// ---------------------------------------------------------------------------
module tb_spw_tx_char_scheduler;

    localparam int MAXC = 56;
    localparam int STEP = 8;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       enableTx, sendNULLs, sendFCTs, sendNChars, sendTimeCodes;
    logic       tickIn;
    logic [7:0] timeIn;
    logic       sendFctReq, sendFctAck;
    logic [8:0] txFifoData;
    logic       txFifoEmpty, txFifoRead;
    logic       gotFCT;
    logic [2:0] charType;
    logic [7:0] charData;
    logic       charValid, charReady;
    logic [5:0] txCredit;
    logic       creditErr;

    spw_tx_char_scheduler #(
        .MAX_CREDIT (MAXC),
        .CREDIT_STEP(STEP),
        .CREDIT_W   (6)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .enableTx     (enableTx),
        .sendNULLs    (sendNULLs),
        .sendFCTs     (sendFCTs),
        .sendNChars   (sendNChars),
        .sendTimeCodes(sendTimeCodes),
        .tickIn       (tickIn),
        .timeIn       (timeIn),
        .sendFctReq   (sendFctReq),
        .sendFctAck   (sendFctAck),
        .txFifoData   (txFifoData),
        .txFifoEmpty  (txFifoEmpty),
        .txFifoRead   (txFifoRead),
        .gotFCT       (gotFCT),
        .charType     (charType),
        .charData     (charData),
        .charValid    (charValid),
        .charReady    (charReady),
        .txCredit     (txCredit),
        .creditErr    (creditErr)
    );

    always #5 CLOCK = ~CLOCK;

    // ---------------------------------------------------------------- checks
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ----------------------------------------------------- show-ahead FIFO
    logic [8:0] fifo[$];
    logic       rd_flag = 1'b0;

    function automatic void fifo_refresh();
        txFifoEmpty = (fifo.size() == 0);
        txFifoData  = (fifo.size() == 0) ? 9'h000 : fifo[0];
    endfunction

    task automatic push(input logic [8:0] w);
        fifo.push_back(w);
        fifo_refresh();
    endtask

    always @(posedge CLOCK) begin
        if (rd_flag && fifo.size() > 0) fifo.delete(0);
        #1 fifo_refresh();
    end

    // ------------------------------------------------------ reference model
    // Tracks the character currently on offer, the credit balance and the
    // pending time-code as plain integers, one clock step at a time.
    bit m_on    = 0;   // enabled for at least one cycle (may choose)
    bit m_valid = 0;
    int m_type  = 0;
    int m_data  = 0;
    int m_credit = 0;
    bit m_err   = 0;
    bit m_pend  = 0;
    int m_tval  = 0;

    always @(posedge CLOCK or posedge RESET) begin
        bit acc;
        int acc_type;
        int new_credit;
        if (RESET || !enableTx) begin
            m_on = 0; m_valid = 0; m_type = 0; m_data = 0;
            m_credit = 0; m_err = 0; m_pend = 0; m_tval = 0;
        end else begin
            acc      = m_valid && charReady;
            acc_type = m_type;
            new_credit = m_credit - ((acc && acc_type >= 2 && acc_type <= 4) ? 1 : 0);
            m_err = 0;
            if (gotFCT) begin
                if (new_credit + STEP > MAXC) m_err = 1;
                else new_credit = new_credit + STEP;
            end
            if (!m_on) begin
                m_on = 1;
            end else if (m_valid) begin
                if (acc) begin m_valid = 0; m_type = 0; m_data = 0; end
            end else begin
                if (m_pend && sendTimeCodes) begin
                    m_valid = 1; m_type = 5; m_data = m_tval;
                end else if (sendFCTs && sendFctReq) begin
                    m_valid = 1; m_type = 1; m_data = 0;
                end else if (sendNChars && !txFifoEmpty && m_credit > 0) begin
                    m_valid = 1;
                    if (txFifoData[8] == 1'b0) begin m_type = 2; m_data = int'(txFifoData[7:0]); end
                    else if (txFifoData[7:0] == 8'h00) begin m_type = 3; m_data = 0; end
                    else begin m_type = 4; m_data = 0; end
                end else if (sendNULLs) begin
                    m_valid = 1; m_type = 0; m_data = 0;
                end
            end
            if (acc && acc_type == 5) m_pend = 0;
            if (tickIn && sendTimeCodes) begin m_pend = 1; m_tval = int'(timeIn); end
            m_credit = new_credit;
        end
    end

    // -------------------------------------------- per-cycle compare + logs
    typedef struct {
        int t;
        int d;
    } char_rec_t;

    char_rec_t acc_log[$];
    int        cred_log[$];
    int        null_cnt = 0;
    int        rd_cnt   = 0;
    int        ack_cnt  = 0;
    int        err_cnt  = 0;
    bit        fct_seen = 0;

    always @(negedge CLOCK) begin
        bit exp_acc;
        exp_acc = enableTx && m_valid && charReady;
        check("charValid", 32'(charValid), 32'(m_valid));
        check("charType", 32'(charType), m_type);
        check("charData", 32'(charData), m_data);
        check("txCredit", 32'(txCredit), m_credit);
        check("creditErr", 32'(creditErr), 32'(m_err));
        check("sendFctAck", 32'(sendFctAck), 32'(exp_acc && m_type == 1));
        check("txFifoRead", 32'(txFifoRead), 32'(exp_acc && m_type >= 2 && m_type <= 4));

        rd_flag = txFifoRead;
        rd_cnt  += int'(txFifoRead);
        ack_cnt += int'(sendFctAck);
        err_cnt += int'(creditErr);
        if (charValid && charReady && enableTx) begin
            if (charType == 3'd0) null_cnt++;
            else acc_log.push_back('{int'(charType), int'(charData)});
            if (charType == 3'd1) fct_seen = 1;
            if (charType >= 3'd2 && charType <= 3'd4) cred_log.push_back(int'(txCredit));
        end
    end

    // -------------------------------------------------------- stimulus aids
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_log(input int n, input int budget, input string what);
        int k;
        k = 0;
        while (acc_log.size() < n && k < budget) begin
            step();
            k++;
        end
        check({what, "_done"}, 32'(acc_log.size() >= n), 32'd1);
    endtask

    task automatic wait_data_offer(input int budget, input string what);
        int k;
        k = 0;
        while (!(charValid && charType == 3'd2) && k < budget) begin
            step();
            k++;
        end
        check({what, "_offer"}, 32'(charValid && charType == 3'd2), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ sequences
    initial begin
        int base, nul0, rd0, err0;
        RESET = 1'b1;
        enableTx = 0; sendNULLs = 0; sendFCTs = 0; sendNChars = 0; sendTimeCodes = 0;
        tickIn = 0; timeIn = 8'h00; sendFctReq = 0; gotFCT = 0; charReady = 0;
        fifo_refresh();
        run(2);
        check("rst_charValid", 32'(charValid), 0);
        check("rst_charType", 32'(charType), 0);
        check("rst_txCredit", 32'(txCredit), 0);
        check("rst_creditErr", 32'(creditErr), 0);
        check("rst_txFifoRead", 32'(txFifoRead), 0);
        RESET = 1'b0;
        run(1);

        // 1. idle NULLs, one every two cycles
        enableTx = 1; sendNULLs = 1; charReady = 1;
        run(4);
        nul0 = null_cnt;
        run(10);
        check("t1_null_count", null_cnt - nul0, 5);
        check("t1_no_reads", rd_cnt, 0);
        check("t1_credit", 32'(txCredit), 0);

        // 5a/2. FIFO holds data but credit is zero: NULLs only
        sendNChars = 1;
        push(9'h0A5);
        push(9'h100);
        run(6);
        check("t5_nocredit_reads", rd_cnt, 0);
        check("t5_nocredit_log", acc_log.size(), 0);
        gotFCT = 1;
        step();
        gotFCT = 0;
        check("t2_credit_after_fct", 32'(txCredit), 8);
        wait_log(2, 30, "t2");
        if (acc_log.size() >= 2) begin
            check("t2_c0_type", acc_log[0].t, 2);
            check("t2_c0_data", acc_log[0].d, 32'hA5);
            check("t2_c1_type", acc_log[1].t, 3);
            check("t2_c1_data", acc_log[1].d, 0);
        end
        if (cred_log.size() >= 2) begin
            check("t2_credit_at_data", cred_log[0], 8);
            check("t2_credit_at_eop", cred_log[1], 7);
        end
        check("t2_credit_final", 32'(txCredit), 6);
        check("t2_reads", rd_cnt, 2);
        nul0 = null_cnt;
        run(6);
        check("t2_nulls_after", 32'(null_cnt > nul0), 1);

        // 3. priority: TIMECODE, then FCT, then DATA
        base = acc_log.size();
        sendNChars = 0; sendFCTs = 1; sendTimeCodes = 1;
        tickIn = 1; timeIn = 8'h3F;
        step();
        tickIn = 0; timeIn = 8'h00;
        sendFctReq = 1; fct_seen = 0;
        push(9'h05A);
        sendNChars = 1;
        for (int k = 0; k < 40 && acc_log.size() < base + 3; k++) begin
            step();
            if (fct_seen) sendFctReq = 0;
        end
        sendFctReq = 0;
        check("t3_done", 32'(acc_log.size() >= base + 3), 1);
        if (acc_log.size() >= base + 3) begin
            check("t3_c0_type", acc_log[base].t, 5);
            check("t3_c0_data", acc_log[base].d, 32'h3F);
            check("t3_c1_type", acc_log[base+1].t, 1);
            check("t3_c2_type", acc_log[base+2].t, 2);
            check("t3_c2_data", acc_log[base+2].d, 32'h5A);
        end
        check("t3_ack_pulses", ack_cnt, 1);

        // 4. credit ceiling
        enableTx = 0;
        run(2);
        check("t4_disabled_credit", 32'(txCredit), 0);
        enableTx = 1; sendNChars = 0; sendNULLs = 1; charReady = 1;
        err0 = err_cnt;
        gotFCT = 1;
        run(7);
        gotFCT = 0;
        check("t4_credit_56", 32'(txCredit), 56);
        check("t4_no_err_yet", err_cnt - err0, 0);
        gotFCT = 1;
        step();
        gotFCT = 0;
        check("t4_err_pulse", 32'(creditErr), 1);
        check("t4_credit_held", 32'(txCredit), 56);
        step();
        check("t4_err_one_cycle", 32'(creditErr), 0);

        sendNULLs = 0;
        run(3);
        rd0 = rd_cnt;
        sendNChars = 1;
        for (int i = 1; i <= 7; i++) push(9'(i));
        for (int k = 0; k < 40 && rd_cnt < rd0 + 7; k++) step();
        check("t4_credit_49", 32'(txCredit), 49);

        charReady = 0;
        push(9'h0EE);
        wait_data_offer(10, "t4a");
        charReady = 1; gotFCT = 1;
        step();
        charReady = 0; gotFCT = 0;
        check("t4_49_fct_credit", 32'(txCredit), 56);
        check("t4_49_fct_noerr", 32'(creditErr), 0);
        push(9'h0EF);
        wait_data_offer(10, "t4b");
        charReady = 1; gotFCT = 1;
        step();
        gotFCT = 0;
        check("t4_56_fct_err", 32'(creditErr), 1);
        check("t4_56_fct_credit", 32'(txCredit), 55);

        // 5b. empty FIFO with credit, and ignored time-code
        sendNULLs = 1;
        base = acc_log.size();
        nul0 = null_cnt;
        run(8);
        check("t5_empty_log", acc_log.size(), base);
        check("t5_empty_nulls", 32'(null_cnt > nul0), 1);
        sendTimeCodes = 0;
        tickIn = 1; timeIn = 8'h11;
        step();
        tickIn = 0; timeIn = 8'h00;
        run(2);
        sendTimeCodes = 1;
        run(8);
        check("t5_tick_ignored", acc_log.size(), base);

        // 6. abort during a held DATA character
        sendNULLs = 0;
        run(3);
        charReady = 0;
        push(9'h0C3);
        wait_data_offer(10, "t6");
        tickIn = 1; timeIn = 8'h77;
        step();
        tickIn = 0; timeIn = 8'h00;
        rd0 = rd_cnt;
        enableTx = 0; charReady = 1;
        step();
        check("t6_valid_dropped", 32'(charValid), 0);
        check("t6_credit_cleared", 32'(txCredit), 0);
        check("t6_no_read", rd_cnt, rd0);
        step();
        enableTx = 1; sendNULLs = 1;
        base = acc_log.size();
        run(8);
        check("t6_no_tick_no_data", acc_log.size(), base);
        check("t6_still_no_read", rd_cnt, rd0);
        gotFCT = 1;
        step();
        gotFCT = 0;
        wait_log(base + 1, 20, "t6");
        if (acc_log.size() >= base + 1) begin
            check("t6_reoffer_type", acc_log[base].t, 2);
            check("t6_reoffer_data", acc_log[base].d, 32'hC3);
        end
        check("t6_reads", rd_cnt, rd0 + 1);

        // 7. reset in the middle of a held character
        charReady = 0;
        run(3);
        check("t7_holding", 32'(charValid), 1);
        RESET = 1'b1;
        #2;
        check("t7_reset_valid", 32'(charValid), 0);
        check("t7_reset_credit", 32'(txCredit), 0);
        check("t7_reset_type", 32'(charType), 0);
        step();
        RESET = 1'b0;
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spw_tx_char_scheduler.md
Name: spw_tx_char_scheduler

Overview:
- Transmit-side character scheduler for the SpaceWire codec. It decides which character the TX encoder sends next: time-code, FCT, N-char from the TX FIFO, or NULL.
- It keeps the transmit credit count, which is raised by FCTs the receiver has received.
- It acknowledges FCT requests from the receive credit logic.
- It sits between the link state machine, the TX FIFO, the RX credit/sync logic and the character encoder.

Parameters:
- MAX_CREDIT, 56: credit ceiling; credit above this is an error.
- CREDIT_STEP, 8: credit added per received FCT.
- CREDIT_W, 6: width of txCredit.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- enableTx  in  1  transmitter enable, from the link FSM.
- sendNULLs, sendFCTs, sendNChars, sendTimeCodes  in  1 each  per-type permissions, from the link FSM.
- tickIn  in  1  time-code request pulse.
- timeIn  in  8  time-code value, qualified by tickIn.
- sendFctReq  in  1  level request from RX credit logic.
- sendFctAck  out  1  FCT accepted.
- txFifoData  in  9  show-ahead FIFO word. Bit 8 = 0 means data. Bit 8 = 1 means EOP if [7:0] = 0, else EEP.
- txFifoEmpty  in  1  FIFO empty.
- txFifoRead  out  1  FIFO pop.
- gotFCT  in  1  received-FCT pulse, already synchronised to CLOCK.
- charType  out  3  0 NULL, 1 FCT, 2 DATA, 3 EOP, 4 EEP, 5 TIMECODE.
- charData  out  8  data byte or time value; 0 for other types.
- charValid  out  1  character offered to the encoder.
- charReady  in  1  encoder accepts the character.
- txCredit  out  CREDIT_W  current credit.
- creditErr  out  1  credit overflow pulse.

Behaviour:
- Reset: all outputs 0, state DISABLED, credit 0, no tick pending.
- FSM states: DISABLED, SELECT, HOLD.
  - DISABLED: charValid = 0. Go to SELECT when enableTx = 1.
  - SELECT: evaluate eligibility in priority order; first eligible wins:
    - TIMECODE: tick pending and sendTimeCodes.
    - FCT: sendFCTs and sendFctReq.
    - N-char: sendNChars, !txFifoEmpty and txCredit > 0.
    - NULL: sendNULLs.
  - SELECT outcome: a winner is registered into charType/charData with charValid = 1, and the FSM goes to HOLD. With no winner, stay in SELECT with charValid = 0. charValid rises exactly one cycle after SELECT.
  - HOLD: charType, charData and charValid are held stable; there is no preemption. An accept is charValid & charReady in the same cycle. After an accept, the next state is SELECT. Minimum issue interval is 2 cycles.
- Accept side effects (combinational, in the accept cycle only):
  - FCT: sendFctAck = 1.
  - DATA/EOP/EEP: txFifoRead = 1 and credit is decremented by 1.
  - TIMECODE: pending tick is cleared.
- Requester assumptions:
  - sendFctReq deasserts by the following cycle.
  - The FIFO presents its next word and updated empty flag by the following cycle.
- Tick handling:
  - tickIn with sendTimeCodes = 1 sets pending and latches timeIn.
  - A tickIn while pending overwrites the value; the latest wins.
  - tickIn with sendTimeCodes = 0 is ignored.
  - tickIn in the same cycle as a TIMECODE accept leaves pending set with the new value.
- Credit update (registered):
  - next = credit − dec + (gotFCT ? CREDIT_STEP : 0), where dec = 1 on an N-char accept.
  - If gotFCT and (credit − dec + CREDIT_STEP) > MAX_CREDIT: credit becomes credit − dec and creditErr = 1 for one cycle.
  - The credit never wraps.
- enableTx = 0 in any state:
  - Next cycle: state DISABLED, charValid = 0, credit = 0, tick pending cleared.
  - No accept side effects in that cycle, even if charReady = 1.
- RESET asserted mid-HOLD aborts immediately to the reset values.

Test Plan:
1. Idle NULLs: enableTx = 1, sendNULLs = 1, other permissions 0, charReady = 1 -> charType = 0 offered every 2 cycles; txFifoRead = 0; txCredit = 0.
2. Data and EOP transfer:
   - Stimulus: sendNChars = 1, one gotFCT, FIFO holds 0x0A5 then 0x100.
   - Response: DATA 0xA5, then EOP; two txFifoRead pulses; txCredit goes 8 -> 7 -> 6; then NULLs.
3. Priority ordering:
   - Stimulus: tickIn with timeIn = 0x3F, sendFctReq = 1 and a non-empty FIFO with credit, all present at the same SELECT.
   - Response: TIMECODE 0x3F, then FCT with a one-cycle sendFctAck, then DATA.
4. Credit overflow:
   - 7 gotFCT -> txCredit = 56.
   - 8th gotFCT -> creditErr high for 1 cycle, txCredit stays 56.
   - At credit 49, gotFCT in the same cycle as an N-char accept -> txCredit = 56, no error.
   - At credit 56, the same case -> creditErr, txCredit = 55.
5. Eligibility gating:
   - FIFO non-empty with credit 0 -> NULL only, no txFifoRead.
   - FIFO empty with credit 8 -> NULL only.
   - tickIn with sendTimeCodes = 0 -> no TIMECODE, even after sendTimeCodes later goes 1.
6. Abort:
   - Stimulus: during HOLD of a DATA char with charReady = 0, drop enableTx.
   - Response: next cycle charValid = 0, txCredit = 0, no txFifoRead; on re-enable the pending tick is gone and the FIFO word is offered again once credit returns.
